// File: rtl/spi_txn_arbiter_if.sv
// Client/master-side bundle of the SPI transaction arbiter.
// The arbiter connects through the slave modport; the requesters and the
// SPI master model connect through the master modport.
interface spi_txn_arbiter_if;
    logic [2:0]  req;
    logic [23:0] req_data;
    logic [5:0]  req_slave;
    logic [2:0]  gnt;
    logic [2:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic [2:0]  err;
    logic        busy;
    logic        start;
    logic [1:0]  slaveSelect;
    logic [7:0]  masterDataToSend;
    logic [7:0]  masterDataReceived;

    modport slave (
        input  req, req_data, req_slave, masterDataReceived,
        output gnt, rsp_valid, rsp_data, err, busy, start, slaveSelect, masterDataToSend
    );

    modport master (
        output req, req_data, req_slave, masterDataReceived,
        input  gnt, rsp_valid, rsp_data, err, busy, start, slaveSelect, masterDataToSend
    );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Round-robin scheduler sharing one SPI master between three requesters.
// One requester is granted at a time; its byte and slave are latched, the
// exchange is timed with a down-counter, and the received byte is returned
// with a one-cycle rsp_valid pulse. All outputs are registered.
module spi_txn_arbiter #(
    parameter int XFER_CYCLES = 9,
    parameter int GAP_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              reset,
    spi_txn_arbiter_if.slave  bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] FIRE  = 3'd2;
    localparam logic [2:0] XFER  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [2:0] GAP   = 3'd5;

    logic [2:0] state_r;
    logic [1:0] rr_r;
    logic [1:0] gnt_idx_r;
    logic [7:0] data_r;
    logic [1:0] slave_r;
    logic [3:0] cnt_r;
    logic [2:0] gnt_r;
    logic [2:0] rsp_valid_r;
    logic [7:0] rsp_data_r;
    logic [2:0] err_r;
    logic       busy_r;
    logic       start_r;
    logic [1:0] ss_r;
    logic [7:0] mdts_r;

    logic       pick_valid_s;
    logic [1:0] pick_idx_s;
    logic [1:0] cand_s;
    logic [1:0] pick_slave_s;
    logic [7:0] pick_data_s;

    // Requester index that follows idx in the 0->1->2->0 rotation.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        if (idx >= 2'd2) begin
            next_idx = 2'd0;
        end else begin
            next_idx = idx + 2'd1;
        end
    endfunction

    // First requesting index at or after the round-robin pointer, with its slave and byte.
    always_comb begin
        pick_valid_s = 1'b0;
        pick_idx_s   = 2'd0;
        cand_s       = rr_r;
        for (int k = 0; k < 3; k++) begin
            if (!pick_valid_s && bus.req[cand_s]) begin
                pick_valid_s = 1'b1;
                pick_idx_s   = cand_s;
            end else begin
                pick_valid_s = pick_valid_s;
            end
            cand_s = next_idx(cand_s);
        end
        pick_slave_s = bus.req_slave[{pick_idx_s, 1'b0} +: 2];
        pick_data_s  = bus.req_data[{pick_idx_s, 3'b000} +: 8];
    end

    // Transaction sequencer: arbitration, master drive, transfer timing and response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            rr_r        <= 2'd0;
            gnt_idx_r   <= 2'd0;
            data_r      <= 8'h00;
            slave_r     <= 2'b11;
            cnt_r       <= 4'd0;
            gnt_r       <= 3'b000;
            rsp_valid_r <= 3'b000;
            rsp_data_r  <= 8'h00;
            err_r       <= 3'b000;
            busy_r      <= 1'b0;
            start_r     <= 1'b0;
            ss_r        <= 2'b11;
            mdts_r      <= 8'h00;
        end else begin
            // Pulse outputs are low unless a state below raises them.
            start_r     <= 1'b0;
            rsp_valid_r <= 3'b000;
            err_r       <= 3'b000;
            case (state_r)
                IDLE: begin
                    if (pick_valid_s && (pick_slave_s == 2'b11)) begin
                        // Illegal target: report and rotate past it, master untouched.
                        err_r <= 3'b001 << pick_idx_s;
                        rr_r  <= next_idx(pick_idx_s);
                    end else if (pick_valid_s) begin
                        gnt_idx_r <= pick_idx_s;
                        gnt_r     <= 3'b001 << pick_idx_s;
                        data_r    <= pick_data_s;
                        slave_r   <= pick_slave_s;
                        busy_r    <= 1'b1;
                        state_r   <= SETUP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SETUP: begin
                    ss_r    <= slave_r;
                    mdts_r  <= data_r;
                    state_r <= FIRE;
                end
                FIRE: begin
                    start_r <= 1'b1;
                    cnt_r   <= 4'(XFER_CYCLES - 1);
                    state_r <= XFER;
                end
                XFER: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                DONE: begin
                    rsp_data_r  <= bus.masterDataReceived;
                    rsp_valid_r <= gnt_r;
                    gnt_r       <= 3'b000;
                    rr_r        <= next_idx(gnt_idx_r);
                    ss_r        <= 2'b11;
                    mdts_r      <= 8'h00;
                    cnt_r       <= 4'(GAP_CYCLES - 1);
                    state_r     <= GAP;
                end
                GAP: begin
                    // The arbitration cycle in IDLE is the last cycle of the gap.
                    if (cnt_r <= 4'd1) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    gnt_r   <= 3'b000;
                    busy_r  <= 1'b0;
                    ss_r    <= 2'b11;
                    mdts_r  <= 8'h00;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt              = gnt_r;
    assign bus.rsp_valid        = rsp_valid_r;
    assign bus.rsp_data         = rsp_data_r;
    assign bus.err              = err_r;
    assign bus.busy             = busy_r;
    assign bus.start            = start_r;
    assign bus.slaveSelect      = ss_r;
    assign bus.masterDataToSend = mdts_r;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Scoreboard bench for spi_txn_arbiter: episodes of requests are turned into
// an expected event list by a transaction-level round-robin model, and a
// negedge monitor matches every grant, start, response and error against it.
module tb_spi_txn_arbiter;
    localparam int XFER_CYCLES = 9;
    localparam int GAP_CYCLES  = 2;
    localparam int K_ERR = 0, K_GNT = 1, K_START = 2, K_RSP = 3;

    typedef struct {
        int         kind;
        int         idx;
        logic [7:0] data;
        logic [1:0] slave;
        int         spacing;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_txn_arbiter_if bus();

    spi_txn_arbiter #(.XFER_CYCLES(XFER_CYCLES), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   rr_m     = 0;
    exp_t q[$];

    bit         mon_en = 1'b0;
    logic [2:0] gnt_prev = 3'b000;
    int         gnt_cyc = 0;
    int         last_gnt_cyc = 0;
    bit         in_xfer = 1'b0;
    logic [1:0] hold_ss;
    logic [7:0] hold_md;
    exp_t       mon_e;
    bit         mon_ok;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic get_exp(input int kind, output exp_t e, output bit ok);
        e  = '{kind: -1, idx: 0, data: 8'h00, slave: 2'd0, spacing: 0};
        ok = 1'b0;
        if (q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: actual event kind %0d required no event", kind);
        end else begin
            e = q.pop_front();
            check("event_kind", kind, e.kind);
            ok = (e.kind == kind);
        end
    endtask

    // Monitor: match DUT events against the scoreboard queue.
    always @(negedge clk) begin
        if (mon_en) begin
            check("gnt_onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
            if (bus.err != 3'b000) begin
                get_exp(K_ERR, mon_e, mon_ok);
                if (mon_ok) begin
                    check("err_bit", bus.err, 3'b001 << mon_e.idx);
                    check("err_busy", bus.busy, 1'b0);
                    check("err_ss_parked", bus.slaveSelect, 2'b11);
                end
            end
            if (bus.gnt != 3'b000 && gnt_prev == 3'b000) begin
                get_exp(K_GNT, mon_e, mon_ok);
                if (mon_ok) begin
                    check("gnt_bit", bus.gnt, 3'b001 << mon_e.idx);
                    if (mon_e.spacing > 0) check("gnt_spacing", cyc - last_gnt_cyc, mon_e.spacing);
                end
                gnt_cyc      = cyc;
                last_gnt_cyc = cyc;
            end
            if (bus.start) begin
                get_exp(K_START, mon_e, mon_ok);
                if (mon_ok) begin
                    check("start_latency", cyc - gnt_cyc, 2);
                    check("start_ss", bus.slaveSelect, mon_e.slave);
                    check("start_mdts", bus.masterDataToSend, mon_e.data);
                    hold_ss = mon_e.slave;
                    hold_md = mon_e.data;
                    in_xfer = 1'b1;
                end
            end else if (in_xfer && bus.rsp_valid == 3'b000) begin
                check("xfer_ss_stable", bus.slaveSelect, hold_ss);
                check("xfer_mdts_stable", bus.masterDataToSend, hold_md);
            end
            if (bus.rsp_valid != 3'b000) begin
                get_exp(K_RSP, mon_e, mon_ok);
                if (mon_ok) begin
                    check("rsp_bit", bus.rsp_valid, 3'b001 << mon_e.idx);
                    check("rsp_data", bus.rsp_data, mon_e.data);
                    check("rsp_latency", cyc - gnt_cyc, 3 + XFER_CYCLES);
                end
                in_xfer = 1'b0;
            end
        end
        gnt_prev = bus.gnt;
    end

    // One episode: model predicts the service order, driver holds requests until served.
    task automatic run_episode(input logic [2:0] mask, input logic [5:0] sl_in,
                               input bit withdraw, input bit scramble);
        logic [7:0] d[3];
        logic [7:0] r[3];
        logic [1:0] sl[3];
        logic [2:0] pend;
        logic [2:0] active;
        int idx, nerr, g;
        bit first;
        for (int i = 0; i < 3; i++) begin
            d[i]  = 8'($urandom);
            r[i]  = 8'($urandom);
            sl[i] = sl_in[2*i +: 2];
        end
        pend = mask; first = 1'b1; nerr = 0;
        while (pend != 3'b000) begin
            idx = 0;
            for (int k = 2; k >= 0; k--) if (pend[(rr_m + k) % 3]) idx = (rr_m + k) % 3;
            pend[idx] = 1'b0;
            rr_m = (idx + 1) % 3;
            if (sl[idx] == 2'd3) begin
                q.push_back('{kind: K_ERR, idx: idx, data: 8'h00, slave: 2'd0, spacing: 0});
                nerr++;
            end else begin
                q.push_back('{kind: K_GNT, idx: idx, data: 8'h00, slave: 2'd0,
                              spacing: first ? -1 : XFER_CYCLES + GAP_CYCLES + 3 + nerr});
                q.push_back('{kind: K_START, idx: idx, data: d[idx], slave: sl[idx], spacing: 0});
                q.push_back('{kind: K_RSP, idx: idx, data: r[idx], slave: 2'd0, spacing: 0});
                first = 1'b0;
                nerr  = 0;
            end
        end
        @(negedge clk);
        bus.req_data  = {d[2], d[1], d[0]};
        bus.req_slave = {sl[2], sl[1], sl[0]};
        bus.req       = mask;
        active        = mask;
        for (int c = 0; c < 400 && (active != 3'b000 || q.size() != 0); c++) begin
            @(negedge clk);
            #1;
            active = active & ~(bus.rsp_valid | bus.err);
            if (bus.gnt != 3'b000) begin
                g = bus.gnt[1] ? 1 : (bus.gnt[2] ? 2 : 0);
                bus.masterDataReceived = r[g];
                if (scramble) begin
                    bus.req_data[8*g +: 8]  = 8'($urandom);
                    bus.req_slave[2*g +: 2] = 2'($urandom);
                end
                if (withdraw && $urandom_range(0, 3) == 0) active = active & ~bus.gnt;
            end
            bus.req = active;
        end
        if (active != 3'b000 || q.size() != 0) begin
            n_checks++;
            $display("FAIL episode_timeout: actual %0d events pending, req %b required none", q.size(), active);
            q.delete();
            in_xfer = 1'b0;
        end
        bus.req = 3'b000;
        for (int c = 0; c < 50 && bus.busy; c++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    // Abort a transfer four cycles into XFER and check the block recovers cleanly.
    task automatic reset_mid_xfer();
        bit seen, stray;
        @(negedge clk);
        mon_en        = 1'b0;
        bus.req_slave = 6'b00_01_00;
        bus.req_data  = 24'h00_5A_00;
        bus.req       = 3'b010;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bus.start) seen = 1'b1;
        end
        check("abort_start_seen", seen, 1'b1);
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_gnt", bus.gnt, 3'b000);
        check("abort_ss", bus.slaveSelect, 2'b11);
        check("abort_start", bus.start, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        bus.req = 3'b000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        stray = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.rsp_valid != 3'b000 || bus.start) stray = 1'b1;
        end
        check("abort_no_rsp", stray, 1'b0);
        rr_m     = 0;
        q.delete();
        in_xfer  = 1'b0;
        gnt_prev = 3'b000;
        mon_en   = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        bus.req = 3'b000;
        bus.req_data = 24'h000000;
        bus.req_slave = 6'b000000;
        bus.masterDataReceived = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_gnt", bus.gnt, 3'b000);
        check("rst_rsp_valid", bus.rsp_valid, 3'b000);
        check("rst_err", bus.err, 3'b000);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_start", bus.start, 1'b0);
        check("rst_ss", bus.slaveSelect, 2'b11);
        check("rst_mdts", bus.masterDataToSend, 8'h00);
        check("rst_rsp_data", bus.rsp_data, 8'h00);
        reset = 1'b0;
        rr_m = 0;
        mon_en = 1'b1;

        run_episode(3'b001, 6'b00_00_10, 1'b0, 1'b0);   // single request to slave 2
        run_episode(3'b111, 6'b10_01_00, 1'b0, 1'b0);   // round robin, slaves 0/1/2
        run_episode(3'b001, 6'b00_00_01, 1'b0, 1'b0);
        run_episode(3'b010, 6'b00_11_00, 1'b0, 1'b0);   // illegal slave
        run_episode(3'b001, 6'b00_00_01, 1'b0, 1'b1);   // latched data/slave
        run_episode(3'b001, 6'b00_00_10, 1'b1, 1'b0);   // withdraw after grant
        reset_mid_xfer();
        run_episode(3'b111, 6'b01_10_00, 1'b0, 1'b0);   // rr restarts at requester 0
        repeat (30) begin
            run_episode(3'($urandom_range(1, 7)), 6'($urandom),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual simulation still running required finished");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Round-robin scheduler that shares one SPI master between three requesters.
- Each requester posts a byte and a target slave. The block grants one requester at a time and drives the master's start, slaveSelect and masterDataToSend.
- It times the 8-bit exchange, captures masterDataReceived, and returns it to the granted requester.
- Sits between the system-side clients and the Master block; all signals are in the master's clk domain.

Parameters:
- XFER_CYCLES, 9, clk cycles from start pulse to capture of received byte (8 bit-times plus 1 settle); legal range 9..15.
- GAP_CYCLES, 2, idle clk cycles between transactions with slaveSelect parked at 2'b11 (CS all high); legal 1..7.

Ports:
- clk input 1 system clock, all logic on rising edge
- reset input 1 asynchronous, active-high
- req input 3 per-requester request, level; bit i = requester i
- req_data input 24 byte to send; requester i at [8i+7:8i]
- req_slave input 6 target slave 0..2; requester i at [2i+1:2i]; value 3 is illegal
- gnt output 3 one-hot grant, held for whole transaction
- rsp_valid output 3 one-cycle pulse on bit of completing requester
- rsp_data output 8 received byte, valid while any rsp_valid bit high
- err output 3 one-cycle pulse: requester asked for slave 3
- busy output 1 high in any state except IDLE
- start output 1 to master start, one-cycle pulse
- slaveSelect output 2 to master slaveSelect
- masterDataToSend output 8 to master data input
- masterDataReceived input 8 from master

Behaviour:
- Reset (async, active-high): state=IDLE; gnt=0, rsp_valid=0, err=0, busy=0, start=0; slaveSelect=2'b11; masterDataToSend=8'h00; rsp_data=8'h00; rr pointer=0 (requester 0 highest priority).
- States: IDLE -> SETUP -> FIRE -> XFER -> DONE -> GAP -> IDLE.
- IDLE: if any req, pick first set bit starting at rr pointer, wrapping 0->1->2->0.
  - Legal slave: latch its data/slave, assert gnt, go SETUP.
  - Slave 3: pulse err for that bit, advance rr pointer past it, stay IDLE; no master activity.
- SETUP (1 cycle): drive slaveSelect and masterDataToSend from the latch; start=0.
- FIRE (1 cycle): start=1. Counter loads XFER_CYCLES-1.
- XFER: start=0; decrement counter each cycle; at 0 go DONE.
  - slaveSelect and masterDataToSend held stable throughout.
- DONE (1 cycle): rsp_data<=masterDataReceived; rsp_valid pulses for granted bit (visible the cycle after DONE entry).
  - gnt drops when leaving DONE; rr pointer = granted index+1 mod 3.
- GAP: slaveSelect=2'b11, masterDataToSend=8'h00; count GAP_CYCLES; then IDLE.
- Latency: grant in IDLE at cycle T -> start high at T+2 -> rsp_valid at T+3+XFER_CYCLES.
  - Minimum spacing between start pulses: XFER_CYCLES+GAP_CYCLES+3.
- req deassertion while granted: ignored; transaction completes and rsp_valid still pulses. Requester must hold req until rsp_valid to be guaranteed service; req high at DONE+GAP is a new request.
- req_data/req_slave changes after grant: ignored (latched).
- Simultaneous requests: exactly one granted per arbitration; no requester starved (served within 3 transactions).
- Reset mid-XFER: immediate return to reset values; no rsp_valid for aborted transaction; slaveSelect=2'b11 deselects slaves.
- start never asserted outside FIRE; gnt never has more than one bit set.

Test Plan:
- Single request: req=3'b001, req_data[7:0]=8'hA5, req_slave[1:0]=2, masterDataReceived=8'h3C during XFER -> slaveSelect=2, masterDataToSend=8'hA5, one start pulse, rsp_valid=3'b001 with rsp_data=8'h3C exactly 3+XFER_CYCLES cycles after grant.
- Round robin: req=3'b111 held, slaves 0/1/2 -> grant order 001,010,100,001.
  - Start pulses spaced XFER_CYCLES+GAP_CYCLES+3 = 14 cycles at defaults.
- Illegal slave: req=3'b010 with req_slave[3:2]=3 -> err=3'b010 for one cycle, no start, slaveSelect stays 2'b11, busy stays 0.
- Stability: req0 granted, then change req_data[7:0] and req_slave[1:0] mid-XFER -> master outputs unchanged until GAP.
- Reset mid-transfer: assert reset at XFER cycle 4 -> same cycle gnt=0, slaveSelect=2'b11, start=0; no rsp_valid afterward.
  - Next request after release is served normally starting from requester 0.
- Request withdraw: req0 drops during XFER -> rsp_valid[0] still pulses; no second grant to requester 0.
